// File: rtl/hpu_out_arbiter_pkg.sv
// Shared types for the output-port arbiter: flit encoding, routing select, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: flit_type_e, flit_t, onehot_sel, FLIT_W, N_PORTS, is_head().
package hpu_out_arbiter_pkg;

  localparam int FLIT_W  = 32;
  // Width of the routing select; sized for the widest supported router (8 ports).
  localparam int N_PORTS = 8;

  typedef enum logic [1:0] {
    HEAD   = 2'b00,
    BODY   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e        typ;
    logic [FLIT_W-1:0] data;
  } flit_t;

  typedef logic [N_PORTS-1:0] onehot_sel;

  // Flit types that may open a new arbitration round.
  function automatic logic is_head(input flit_type_e t);
    return (t == HEAD) || (t == SINGLE);
  endfunction

endpackage

// File: rtl/hpu_out_arbiter_if.sv
// Flit handshake bundle between the HPUs, one output-port arbiter and the downstream stage.
// Latency: n/a (wires only).
// Backpressure: in_ready per input, out_ready from downstream.
//
// Signals: in_valid/in_flit/in_sel (per input), in_ready (per input),
//          out_valid/out_flit/out_ready. Modports: master (upstream+downstream side), slave (arbiter).
interface hpu_out_arbiter_if
  import hpu_out_arbiter_pkg::*;
#(
  parameter int N_IN = 5
);

  logic      [N_IN-1:0] in_valid;
  flit_t     [N_IN-1:0] in_flit;
  onehot_sel [N_IN-1:0] in_sel;
  logic      [N_IN-1:0] in_ready;
  logic                 out_valid;
  flit_t                out_flit;
  logic                 out_ready;

  modport master (
    output in_valid, in_flit, in_sel, out_ready,
    input  in_ready, out_valid, out_flit
  );

  modport slave (
    input  in_valid, in_flit, in_sel, out_ready,
    output in_ready, out_valid, out_flit
  );

endinterface

// File: rtl/hpu_out_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit scanning from ptr upward, wrapping at N_IN.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports: req[N_IN] in, ptr in, gnt[N_IN] onehot out, any out.
module hpu_out_arbiter_rr_pick #(
  parameter int N_IN = 5
) (
  input  logic [N_IN-1:0]         req,
  input  logic [$clog2(N_IN)-1:0] ptr,
  output logic [N_IN-1:0]         gnt,
  output logic                    any
);

  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    any = 1'b0;
    for (int off = 0; off < N_IN; off++) begin
      idx = (int'(ptr) + off) % N_IN;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpu_out_arbiter.sv
// Wormhole output-port arbiter: round-robin per packet, grant held head..tail, one output register.
// Latency: 1 cycle from input accept to out_valid; full rate while out_ready stays high.
// Backpressure: inputs are accepted only when the output register is empty or draining.
//
// Ports: clk, preset_n (async active-low), bus (slave modport: per-input flits, registered output),
//        grant (onehot owner while LOCKED), busy (LOCKED), wd_err (sticky stall error).
// Build option: OUTARB_WATCHDOG_EN adds the LOCKED-stall watchdog and the wd_err port.
module hpu_out_arbiter
  import hpu_out_arbiter_pkg::*;
#(
  parameter int N_IN      = 5,
  parameter int THIS_PORT = 0,
  parameter int WD_CYCLES = 64
) (
  input  logic              clk,
  input  logic              preset_n,
  hpu_out_arbiter_if.slave  bus,
  output logic [N_IN-1:0]   grant,
  output logic              busy
`ifdef OUTARB_WATCHDOG_EN
  ,
  output logic              wd_err
`endif
);

  localparam int PTR_W = $clog2(N_IN);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [PTR_W-1:0] rr_ptr;

  logic [N_IN-1:0]  req;
  logic [N_IN-1:0]  eligible;
  logic [N_IN-1:0]  pick_gnt;
  logic             pick_any;
  logic             can_accept;
  logic [N_IN-1:0]  xfer;
  logic             xfer_any;
  flit_t            xfer_flit;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] next_ptr;

  // Only bit THIS_PORT of each select matters here.
  logic unused_sel;
  assign unused_sel = ^bus.in_sel;

  always_comb begin
    req      = '0;
    eligible = '0;
    for (int i = 0; i < N_IN; i++) begin
      req[i]      = bus.in_valid[i] & bus.in_sel[i][THIS_PORT];
      // BODY/TAIL requesting while idle is a protocol violation and never wins.
      eligible[i] = req[i] & is_head(bus.in_flit[i].typ);
    end
  end

  hpu_out_arbiter_rr_pick #(.N_IN(N_IN)) u_pick (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  assign can_accept = !bus.out_valid || bus.out_ready;

  always_comb begin
    bus.in_ready = '0;
    if (state == LOCKED)
      // Owner's select is ignored: body flits carry no route.
      bus.in_ready = grant & {N_IN{can_accept}};
    else if (pick_any && can_accept)
      bus.in_ready = pick_gnt;
    // Keep in_ready quiet while reset is held, not just after the next edge.
    if (!preset_n)
      bus.in_ready = '0;
  end

  assign xfer     = bus.in_valid & bus.in_ready;
  assign xfer_any = |xfer;

  always_comb begin
    win_idx   = '0;
    xfer_flit = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (xfer[i]) begin
        win_idx   = PTR_W'(i);
        xfer_flit = bus.in_flit[i];
      end
    end
  end

  assign next_ptr = (win_idx == PTR_W'(N_IN - 1)) ? '0 : win_idx + PTR_W'(1);
  assign busy     = (state == LOCKED);

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_flit  <= '0;
    end else begin
      if (xfer_any) begin
        bus.out_flit  <= xfer_flit;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (state == IDLE) begin
        if (xfer_any) begin
          rr_ptr <= next_ptr;
          if (xfer_flit.typ == HEAD) begin
            state <= LOCKED;
            grant <= xfer;
          end
        end
      end else if (xfer_any && xfer_flit.typ == TAIL) begin
        state <= IDLE;
        grant <= '0;
      end
    end
  end

`ifdef OUTARB_WATCHDOG_EN
  localparam logic [15:0] WD_LIM = 16'(WD_CYCLES);

  logic [15:0] wd_cnt;

  // Counts LOCKED cycles without a transfer; saturates and never touches arbitration.
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else if (state == LOCKED && !xfer_any) begin
      if (wd_cnt != WD_LIM)
        wd_cnt <= wd_cnt + 16'd1;
      if (wd_cnt == WD_LIM - 16'd1)
        wd_err <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

endmodule
